axis_width_upsizer: RTL and testbench

AXI-Stream width upsizer. Packs RATIO consecutive narrow input beats into one wide output beat, little-endian: the first beat goes in the LS lane.
Sits directly upstream of the AXI-S register slice in the stream path. The slice absorbs this block's combinational tready path and delivers the wide words to downstream consumers.
Supports early termination on tlast, which produces a partial word marked by tkeep.

---
 rtl/axis_pkg.sv | 19 +
 rtl/axis_width_upsizer.sv | 116 +++++++++++
 tb/tb_axis_width_upsizer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: counter sizing, lane slicing and reset polarity.
package axis_pkg;

  // Reset level at which the async reset is asserted (active-low).
  localparam logic RESET_ASSERTED = 1'b0;

  // Width of a counter that must hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = $clog2(value);
    return (bits < 1) ? 1 : bits;
  endfunction

  // LSB position of lane 'lane' in a word built from lanes of 'lane_width' bits.
  function automatic int lane_lsb(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/axis_width_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide word, first beat in lane 0.
// Optional macro AXIS_UPSIZER_TLAST_EN adds tlast ports and early close into partial words.
module axis_width_upsizer
  import axis_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]       s_axis_tdata,
`ifdef AXIS_UPSIZER_TLAST_EN
  input  logic                      s_axis_tlast,
`endif
  output logic                      s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [IN_WIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]          m_axis_tkeep,
`ifdef AXIS_UPSIZER_TLAST_EN
  output logic                      m_axis_tlast,
`endif
  input  logic                      m_axis_tready
);

  localparam int               OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int               CNT_W     = clog2_min1(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] acc_data;
  logic [OUT_WIDTH-1:0] merged_data;
  logic                 accept;
  logic                 beat_last;
  logic                 close;

`ifdef AXIS_UPSIZER_TLAST_EN
  logic [RATIO-1:0] acc_keep;
  logic [RATIO-1:0] merged_keep;

  assign beat_last = s_axis_tlast;
`else
  assign beat_last = 1'b0;
`endif

  // Combinational ready by design; the downstream register slice breaks this path.
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign close         = accept & ((cnt == CNT_LAST) | beat_last);

  always_comb begin
    merged_data = acc_data;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) begin
        merged_data[lane_lsb(k, IN_WIDTH) +: IN_WIDTH] = s_axis_tdata;
      end
    end
  end

`ifdef AXIS_UPSIZER_TLAST_EN
  always_comb begin
    merged_keep = acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) begin
        merged_keep[k] = 1'b1;
      end
    end
  end
`endif

  // Cleared accumulator lanes are what leave unfilled lanes of a partial word at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n == RESET_ASSERTED) begin
      cnt      <= '0;
      acc_data <= '0;
    end else if (close) begin
      cnt      <= '0;
      acc_data <= '0;
    end else if (accept) begin
      cnt      <= cnt + 1'b1;
      acc_data <= merged_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n == RESET_ASSERTED) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (close) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= merged_data;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_UPSIZER_TLAST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n == RESET_ASSERTED) begin
      acc_keep     <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
    end else if (close) begin
      acc_keep     <= '0;
      m_axis_tkeep <= merged_keep;
      m_axis_tlast <= s_axis_tlast;
    end else if (accept) begin
      acc_keep     <= merged_keep;
    end
  end
`else
  // Without tlast every word closes full, so all lanes always hold data.
  assign m_axis_tkeep = '1;
`endif

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed self-checking bench for axis_width_upsizer (RATIO=4 and RATIO=1 instances).
// Tlast-specific steps are built only when AXIS_UPSIZER_TLAST_EN is defined.
`timescale 1ns/1ps
module tb_axis_width_upsizer;

`ifdef AXIS_UPSIZER_TLAST_EN
  localparam logic [3:0] KEEP_RST4 = 4'h0;
  localparam logic [0:0] KEEP_RST1 = 1'b0;
`else
  localparam logic [3:0] KEEP_RST4 = 4'hF;
  localparam logic [0:0] KEEP_RST1 = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;

  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tready;

  logic        s1_tvalid;
  logic [7:0]  s1_tdata;
  logic        s1_tready;
  logic        m1_tvalid;
  logic [7:0]  m1_tdata;
  logic [0:0]  m1_tkeep;
  logic        m1_tready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_width_upsizer #(.IN_WIDTH(8), .RATIO(4)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
`ifdef AXIS_UPSIZER_TLAST_EN
    .s_axis_tlast  (s_tlast),
`endif
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
`ifdef AXIS_UPSIZER_TLAST_EN
    .m_axis_tlast  (m_tlast),
`endif
    .m_axis_tready (m_tready)
  );

  axis_width_upsizer #(.IN_WIDTH(8), .RATIO(1)) u_dut1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tvalid (s1_tvalid),
    .s_axis_tdata  (s1_tdata),
`ifdef AXIS_UPSIZER_TLAST_EN
    .s_axis_tlast  (1'b0),
`endif
    .s_axis_tready (s1_tready),
    .m_axis_tvalid (m1_tvalid),
    .m_axis_tdata  (m1_tdata),
    .m_axis_tkeep  (m1_tkeep),
`ifdef AXIS_UPSIZER_TLAST_EN
    .m_axis_tlast  (),
`endif
    .m_axis_tready (m1_tready)
  );

`ifndef AXIS_UPSIZER_TLAST_EN
  assign m_tlast = 1'b0;
`endif

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] data, input logic last);
    s_tvalid = valid;
    s_tdata  = data;
    s_tlast  = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_words [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sent;
    int          widx;
    logic        hs;
    logic        acc;
    logic [31:0] obs;

    reset_n   = 1'b0;
    m_tready  = 1'b1;
    s1_tvalid = 1'b0;
    s1_tdata  = 8'h00;
    m1_tready = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0);
    step();
    step();
    check_output("rst_tvalid", 32'(m_tvalid), 32'h0);
    check_output("rst_tdata", m_tdata, 32'h0);
    check_output("rst_tkeep", 32'(m_tkeep), 32'(KEEP_RST4));
    check_output("rst_s_tready", 32'(s_tready), 32'h1);
    check_output("rst1_tvalid", 32'(m1_tvalid), 32'h0);
    check_output("rst1_tkeep", 32'(m1_tkeep), 32'(KEEP_RST1));
    reset_n = 1'b1;
    step();

    $display("[TB] full word, back-to-back beats");
    apply_stimulus(1'b1, 8'h11, 1'b0);
    check_output("t1_s_tready0", 32'(s_tready), 32'h1);
    step();
    apply_stimulus(1'b1, 8'h22, 1'b0);
    check_output("t1_s_tready1", 32'(s_tready), 32'h1);
    check_output("t1_tvalid_early", 32'(m_tvalid), 32'h0);
    step();
    apply_stimulus(1'b1, 8'h33, 1'b0);
    check_output("t1_s_tready2", 32'(s_tready), 32'h1);
    step();
    apply_stimulus(1'b1, 8'h44, 1'b0);
    check_output("t1_s_tready3", 32'(s_tready), 32'h1);
    check_output("t1_tvalid_pre", 32'(m_tvalid), 32'h0);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t1_tvalid", 32'(m_tvalid), 32'h1);
    check_output("t1_tdata", m_tdata, 32'h44332211);
    check_output("t1_tkeep", 32'(m_tkeep), 32'hF);
    step();
    check_output("t1_tvalid_drop", 32'(m_tvalid), 32'h0);

`ifdef AXIS_UPSIZER_TLAST_EN
    $display("[TB] early tlast partial word");
    apply_stimulus(1'b1, 8'hAA, 1'b0);
    step();
    apply_stimulus(1'b1, 8'hBB, 1'b1);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t2_tvalid", 32'(m_tvalid), 32'h1);
    check_output("t2_tdata", m_tdata, 32'h0000BBAA);
    check_output("t2_tkeep", 32'(m_tkeep), 32'h3);
    check_output("t2_tlast", 32'(m_tlast), 32'h1);
    step();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'(8'hC1 + i), (i == 3));
      step();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t2_full_tdata", m_tdata, 32'hC4C3C2C1);
    check_output("t2_full_tkeep", 32'(m_tkeep), 32'hF);
    check_output("t2_full_tlast", 32'(m_tlast), 32'h1);
    step();
`endif

    $display("[TB] backpressure holds output stable");
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'(8'h01 + i), 1'b0);
      step();
    end
    apply_stimulus(1'b1, 8'h05, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_output("t3_hold_tvalid", 32'(m_tvalid), 32'h1);
      check_output("t3_hold_tdata", m_tdata, 32'h04030201);
      check_output("t3_hold_s_tready", 32'(s_tready), 32'h0);
      step();
    end
    m_tready = 1'b1;
    #1;
    check_output("t3_release_s_tready", 32'(s_tready), 32'h1);
    step();
    check_output("t3_drained_tvalid", 32'(m_tvalid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 8'(8'h06 + i), 1'b0);
      step();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t3_word2_tvalid", 32'(m_tvalid), 32'h1);
    check_output("t3_word2_tdata", m_tdata, 32'h08070605);
    step();
    check_output("t3_word2_drop", 32'(m_tvalid), 32'h0);

    $display("[TB] toggling downstream ready");
    sent = 0;
    widx = 0;
    for (int cyc = 0; cyc < 200 && widx < 4; cyc++) begin
      m_tready = cyc[0];
      if (sent < 16) apply_stimulus(1'b1, 8'(8'h10 + sent), 1'b0);
      else           apply_stimulus(1'b0, 8'h00, 1'b0);
      #1;
      hs  = m_tvalid & m_tready;
      obs = m_tdata;
      acc = s_tvalid & s_tready;
      step();
      if (hs) begin
        check_output("t4_word", obs, exp_words[widx]);
        widx++;
      end
      if (acc) sent++;
    end
    check_output("t4_word_count", 32'(widx), 32'd4);
    check_output("t4_beats_sent", 32'(sent), 32'd16);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    m_tready = 1'b1;
    step();
    step();

    $display("[TB] asynchronous reset mid-frame");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 8'(8'h01 + i), 1'b0);
      step();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_output("t5_rst_tvalid", 32'(m_tvalid), 32'h0);
    check_output("t5_rst_tdata", m_tdata, 32'h0);
    step();
    #4;
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'(8'h55 + 8'h11 * i), 1'b0);
      step();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("t5_tvalid", 32'(m_tvalid), 32'h1);
    check_output("t5_tdata", m_tdata, 32'h88776655);
    check_output("t5_tkeep", 32'(m_tkeep), 32'hF);
    step();

    $display("[TB] RATIO=1 pipe");
    s1_tvalid = 1'b1;
    s1_tdata  = 8'h5A;
    step();
    check_output("t6_tvalid0", 32'(m1_tvalid), 32'h1);
    check_output("t6_tdata0", 32'(m1_tdata), 32'h5A);
    check_output("t6_tkeep0", 32'(m1_tkeep), 32'h1);
    s1_tdata = 8'h3C;
    step();
    check_output("t6_tdata1", 32'(m1_tdata), 32'h3C);
    m1_tready = 1'b0;
    s1_tdata  = 8'h77;
    #1;
    check_output("t6_stall_s_tready", 32'(s1_tready), 32'h0);
    step();
    check_output("t6_stall_tdata", 32'(m1_tdata), 32'h3C);
    check_output("t6_stall_tvalid", 32'(m1_tvalid), 32'h1);
    m1_tready = 1'b1;
    step();
    s1_tvalid = 1'b0;
    check_output("t6_tdata2", 32'(m1_tdata), 32'h77);
    check_output("t6_tvalid2", 32'(m1_tvalid), 32'h1);
    step();
    check_output("t6_tvalid_drop", 32'(m1_tvalid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
